seq_detector_prog: RTL and testbench
====================================

Name: seq_detector_prog

Overview:
Runtime-programmable serial bit-pattern detector.
- Pattern and length are loadable from configuration, up to PAT_W bits.
- Overlapping or non-overlapping matching is selectable.
- Produces a registered single-cycle match pulse and a saturating match counter.
- Sits on a serial input stream; the match pulse feeds downstream control or interrupt logic.

Parameters:
- PAT_W, 8, maximum pattern length in bits (2..32).
- CNT_W, 16, match counter width.
- LEN_W, $clog2(PAT_W)+1, width of length fields (derived; not overridden).

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_bit is sampled this cycle.
- in_bit  in  1  serial data bit.
- cfg_load  in  1  latch cfg_pattern/cfg_len/cfg_overlap into the active configuration.
- cfg_pattern  in  PAT_W  pattern; bit [len-1] is received first, bit [0] last.
- cfg_len  in  LEN_W  pattern length in bits.
- cfg_overlap  in  1  1 = overlapping matches allowed; 0 = history cleared after each match.
- cnt_clr  in  1  clear match_count.
- match  out  1  one-cycle pulse: the pattern completed on the previous accepted bit.
- match_count  out  CNT_W  number of matches, saturating.
- cnt_sat  out  1  match_count is at all-ones.

Behaviour:
- Reset (rst=1 at an edge):
  - hist=0, fill=0, match=0, match_count=0, cnt_sat=0.
  - Active config: pattern=0, len=0, overlap=0, so the detector is disabled until the first cfg_load.
  - Reset mid-stream discards all partial history.
- Configuration:
  - On cfg_load, latch cfg_pattern, clamp(cfg_len), and cfg_overlap; also clear hist and fill.
  - Clamp rule: cfg_len > PAT_W loads PAT_W. cfg_len = 0 loads 0, and len=0 never matches.
  - cfg_load has priority over in_valid in the same cycle; that bit is discarded and not counted.
  - Counters are unaffected by cfg_load.
- Data path, on an edge with in_valid=1 and no cfg_load:
  - hist <= {hist[PAT_W-2:0], in_bit}.
  - fill <= min(fill+1, PAT_W).
  - in_valid=0 holds all state.
- Match condition, evaluated combinationally on the post-shift values:
  - len != 0, and fill_next >= len, and hist_next[len-1:0] == pattern[len-1:0].
  - Bits above len are masked.
- Match response:
  - match is registered: high for exactly one cycle after the edge that accepted the final pattern bit.
  - Latency is 1 clock from sampling the last bit, as in a Moore-style output.
  - overlap=1: hist and fill continue normally, so a suffix of one match can begin the next.
  - overlap=0: on a match, fill <= 0 (hist contents are irrelevant while fill < len), so the next match needs len fresh bits.
- Counter:
  - match_count increments on each match pulse edge (the same edge that sets match).
  - It saturates at 2^CNT_W-1 and does not wrap; cnt_sat = (match_count == all-ones).
  - cnt_clr has priority over holding. cnt_clr coincident with an increment yields match_count=1, so the match is not lost.
  - cnt_clr while saturated yields 0 (or 1 if a match coincides).
- Back-to-back:
  - A match on consecutive accepted bits is possible (overlap=1, pattern such as 11 on a run of ones).
  - match then stays high on consecutive cycles, one pulse per match.
- No internal FSM state beyond hist, fill, and the registered outputs; there are no illegal states.

Decomposition:
- Package seq_det_pkg holds:
  - the LEN_W derivation function (clog2-based);
  - typedef cfg_t (pattern, len, overlap) as a packed struct parameterised via the package default PAT_W;
  - constant CFG_RESET (all zeros).
- One sub-module, seq_det_sat_counter (CNT_W, inc, clr -> count, sat), instantiated for match_count.
- Shift/compare logic stays in the top module.

Test Plan:
- Legacy equivalence: load pattern=0001, len=4, overlap=0; feed 0,0,0,1,0,0,0,1 with in_valid=1 -> match high one cycle after the 4th and 8th bits; match_count=2.
- Overlap mode: load 101, len=3, overlap=1; feed 1,0,1,0,1 -> two pulses (after bits 3 and 5). Same stream with overlap=0 -> one pulse; count=1.
- Gaps and clamp:
  - pattern 0110, len=4, with in_valid deasserted for 3 cycles between each bit -> a single match, one cycle after the last valid bit.
  - cfg_len=15 with PAT_W=8 -> effective len 8, verified by an 8-bit pattern match.
- Priority:
  - cfg_load with in_valid=1 on the final pattern bit -> no match, history cleared.
  - cnt_clr coincident with a match at count=5 -> match_count=1.
- Saturation: CNT_W=4, pattern 11, len=2, overlap=1, feed 20 ones -> count reaches 15, cnt_sat=1, no wrap; cnt_clr -> 0, cnt_sat=0.
- Reset mid-operation: after 3 of 4 pattern bits, assert rst one cycle, reload config, feed the final bit only -> no match; match/match_count/cnt_sat=0 during and after reset.

Source files
------------

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared length-width helper, default config struct and its reset value
package seq_det_pkg;
  localparam int DEF_PAT_W = 8;
  function automatic int len_w(input int pat_w);
    return $clog2(pat_w) + 1;
  endfunction
  localparam int DEF_LEN_W = len_w(DEF_PAT_W);
  typedef struct packed {
    logic [DEF_PAT_W-1:0] pattern;
    logic [DEF_LEN_W-1:0] len;
    logic                 overlap;
  } cfg_t;
  localparam cfg_t CFG_RESET = '0;
endpackage

// File: rtl/seq_det_sat_counter.sv
// seq_det_sat_counter: saturating up-counter (clk, rst, inc, clr -> count, sat); clr wins but keeps a coincident inc
module seq_det_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat
);
  assign sat = &count;
  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else if (clr) count <= CNT_W'(inc);
    else if (inc && !sat) count <= count + CNT_W'(1);
  end
endmodule

// File: rtl/seq_detector_prog.sv
// seq_detector_prog: programmable serial pattern detector (in_valid/in_bit stream, cfg_* load, cnt_clr -> match pulse, match_count, cnt_sat)
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter  int PAT_W = 8,
  parameter  int CNT_W = 16,
  localparam int LEN_W = len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             cnt_sat
);
  typedef struct packed {
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic             overlap;
  } act_cfg_t;
  act_cfg_t         cfg;
  logic [PAT_W-1:0] hist, hist_next, mask;
  logic [LEN_W-1:0] fill, fill_next;
  logic             accept, hit;
  assign accept    = in_valid && !cfg_load;
  assign hist_next = {hist[PAT_W-2:0], in_bit};
  assign fill_next = (fill == LEN_W'(PAT_W)) ? fill : fill + LEN_W'(1);
  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) mask[i] = (i < int'(cfg.len));
  end
  assign hit = accept && (cfg.len != '0) && (fill_next >= cfg.len) &&
               (((hist_next ^ cfg.pattern) & mask) == '0);
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg   <= '0;
      hist  <= '0;
      fill  <= '0;
      match <= 1'b0;
    end else begin
      match <= hit;
      if (cfg_load) begin
        cfg.pattern <= cfg_pattern;
        cfg.len     <= (cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : cfg_len;
        cfg.overlap <= cfg_overlap;
        hist        <= '0;
        fill        <= '0;
      end else if (in_valid) begin
        hist <= hist_next;
        // non-overlapping: a match forces the next one to collect a full fresh pattern
        fill <= (hit && !cfg.overlap) ? '0 : fill_next;
      end
    end
  end
  seq_det_sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit),
    .clr   (cnt_clr),
    .count (match_count),
    .sat   (cnt_sat)
  );
endmodule

// File: tb/tb_seq_detector_prog.sv
// tb_seq_detector_prog: directed scoreboard bench for seq_detector_prog
module tb_seq_detector_prog;
  localparam int PAT_W = 8;
  localparam int CNT_W = 4;
  localparam int LEN_W = 4;
  logic clk = 1'b0;
  logic rst = 1'b1, in_valid = 1'b0, in_bit = 1'b0, cfg_load = 1'b0, cfg_overlap = 1'b0, cnt_clr = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic match, cnt_sat;
  logic [CNT_W-1:0] match_count;
  int errors = 0, checks = 0;
  logic exp_q[$];
  always #5 clk = ~clk;
  seq_detector_prog #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
    .match(match), .match_count(match_count), .cnt_sat(cnt_sat)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic exp);
    logic e;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    in_valid = 0; cfg_load = 0; cnt_clr = 0; rst = 0;
    if (exp_q.size() == 0) chk("scoreboard_empty", 1, 0);
    else begin
      e = exp_q.pop_front();
      chk("match", match, e);
    end
  endtask
  task automatic send(input logic b, input logic exp);
    in_valid = 1; in_bit = b;
    step(exp);
  endtask
  task automatic idle(input int n);
    repeat (n) step(0);
  endtask
  task automatic load(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l, input logic ov);
    cfg_load = 1; cfg_pattern = p; cfg_len = l; cfg_overlap = ov;
    step(0);
  endtask
  task automatic clr();
    cnt_clr = 1;
    step(0);
    chk("clr_count", match_count, 0);
  endtask
  initial begin
    logic [7:0] p8;
    idle(2);
    chk("rst_count", match_count, 0);
    chk("rst_sat", cnt_sat, 0);
    // disabled before any cfg_load
    send(0, 0); send(0, 0);
    // legacy 0001 non-overlapping
    load(8'b0001, 4, 0);
    send(0, 0); send(0, 0); send(0, 0); send(1, 1);
    send(0, 0); send(0, 0); send(0, 0); send(1, 1);
    chk("legacy_count", match_count, 2);
    // 101 overlapping vs non-overlapping
    clr();
    load(8'b101, 3, 1);
    send(1, 0); send(0, 0); send(1, 1); send(0, 0); send(1, 1);
    chk("ovl_count", match_count, 2);
    clr();
    load(8'b101, 3, 0);
    send(1, 0); send(0, 0); send(1, 1); send(0, 0); send(1, 0);
    chk("novl_count", match_count, 1);
    // gaps between valid bits
    clr();
    load(8'b0110, 4, 0);
    send(0, 0); idle(3); send(1, 0); idle(3); send(1, 0); idle(3); send(0, 1); idle(2);
    chk("gap_count", match_count, 1);
    // length clamp 15 -> 8
    clr();
    p8 = 8'b1011_0011;
    load(p8, 15, 0);
    for (int i = 7; i >= 0; i--) send(p8[i], i == 0);
    chk("clamp_count", match_count, 1);
    // cfg_load beats in_valid on the final bit
    clr();
    load(8'b0110, 4, 0);
    send(0, 0); send(1, 0); send(1, 0);
    cfg_load = 1; in_valid = 1; in_bit = 0;
    step(0);
    send(0, 0);
    chk("prio_count", match_count, 0);
    // cnt_clr coincident with a match at count 5
    load(8'b11, 2, 1);
    clr();
    send(1, 0);
    repeat (5) send(1, 1);
    chk("pre_clr_count", match_count, 5);
    cnt_clr = 1;
    send(1, 1);
    chk("clr_inc_count", match_count, 1);
    // saturation
    load(8'b11, 2, 1);
    clr();
    for (int i = 0; i < 20; i++) begin
      send(1, i > 0);
      if (i == 14) begin
        chk("sat14_count", match_count, 14);
        chk("sat14_flag", cnt_sat, 0);
      end
      if (i == 15) chk("sat15_flag", cnt_sat, 1);
    end
    chk("sat_count", match_count, 15);
    chk("sat_flag", cnt_sat, 1);
    clr();
    chk("sat_clr_flag", cnt_sat, 0);
    // reset mid-stream
    load(8'b0001, 4, 0);
    send(0, 0); send(0, 0); send(0, 0); send(1, 1);
    send(0, 0); send(0, 0); send(0, 0);
    rst = 1;
    step(0);
    chk("rst_mid_count", match_count, 0);
    chk("rst_mid_sat", cnt_sat, 0);
    load(8'b0001, 4, 0);
    send(1, 0);
    idle(1);
    chk("rst_after_count", match_count, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
